// File: rtl/serial_bus_slave.sv
// serial_bus_slave: slave-side port of the single-wire serial system bus.
// Decodes master frames (start, ID, address, optional write data) aimed at
// SELF_ID and turns writes into a one-cycle parallel strobe to local memory.
// Reads present the address, wait for memory data, then shift the data back
// onto the bus once the arbiter grants it. Every field travels LSB first, one
// bit per clock.
module serial_bus_slave #(
    parameter int         ADDRESS_WIDTH = 15,
    parameter int         DATA_WIDTH    = 8,
    parameter logic [2:0] SELF_ID       = 3'b110
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rd_wrt,
    input  logic                     bus_util,
    input  logic                     module_dv,
    inout  wire                      data_bus_serial,
    input  logic                     arbiter_cmd_in,
    input  logic [DATA_WIDTH-1:0]    data_in_parellel,
    output logic                     write_en_internal,
    output logic [DATA_WIDTH-1:0]    data_out_parellel,
    output logic [ADDRESS_WIDTH-1:0] addr_buff,
    output logic                     busy_out
);

    // One counter serves every serial field, so it must reach the wider of the
    // address width and DATA_WIDTH (the TX phase counts start bit + data bits).
    localparam int MAX_W = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CNT_W = (MAX_W < 3) ? 2 : $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ADDR,
        WDATA,
        WRITE,
        WAIT_DV,
        WAIT_GNT,
        TX,
        SKIP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [2:0]              id_shift;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic                    skip_data;
    logic                    bus_bit;
    logic                    id_match;
    logic                    drive_en;
    logic                    drive_bit;

    // The bus is only ever driven while transmitting a read response.
    assign bus_bit         = data_bus_serial;
    assign data_bus_serial = drive_en ? drive_bit : 1'bz;

    // The third ID bit arrives on the wire while the first two sit in id_shift.
    assign id_match = ({bus_bit, id_shift[2:1]} == SELF_ID);

    // State register; reset aborts any transaction, including a TX in flight.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the outputs that follow directly from the state.
    always_comb begin
        next_state        = state;
        write_en_internal = 1'b0;
        busy_out          = 1'b0;
        drive_en          = 1'b0;
        drive_bit         = 1'b0;

        case (state)
            IDLE: begin
                // Only a driven 0 while the master owns the bus counts as a
                // start bit; a floating or high line is ignored.
                if (!bus_util && (bus_bit == 1'b0)) begin
                    next_state = ID;
                end
            end
            ID: begin
                if (bit_cnt == ID_LAST) begin
                    next_state = id_match ? ADDR : SKIP;
                end
            end
            ADDR: begin
                busy_out = 1'b1;
                if (bit_cnt == ADDR_LAST) begin
                    next_state = rd_wrt ? WDATA : WAIT_DV;
                end
            end
            WDATA: begin
                busy_out = 1'b1;
                if (bit_cnt == DATA_LAST) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                busy_out          = 1'b1;
                write_en_internal = 1'b1;
                next_state        = IDLE;
            end
            WAIT_DV: begin
                busy_out = 1'b1;
                if (module_dv) begin
                    next_state = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                busy_out = 1'b1;
                if (arbiter_cmd_in) begin
                    next_state = TX;
                end
            end
            TX: begin
                busy_out  = 1'b1;
                drive_en  = 1'b1;
                // Count 0 is the start bit; after that the shifter's LSB.
                drive_bit = (bit_cnt == '0) ? 1'b0 : tx_shift[0];
                if (bit_cnt == TX_LAST) begin
                    next_state = IDLE;
                end
            end
            SKIP: begin
                // A foreign frame is tracked bit by bit so its payload is
                // never mistaken for a new start bit.
                if (!skip_data && (bit_cnt == ADDR_LAST) && !rd_wrt) begin
                    next_state = IDLE;
                end else if (skip_data && (bit_cnt == DATA_LAST)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: bit counter, field shifters and the read-data holding register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            bit_cnt           <= '0;
            id_shift          <= '0;
            tx_shift          <= '0;
            skip_data         <= 1'b0;
            addr_buff         <= '0;
            data_out_parellel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    skip_data <= 1'b0;
                end
                ID: begin
                    id_shift <= {bus_bit, id_shift[2:1]};
                    bit_cnt  <= (bit_cnt == ID_LAST) ? '0 : bit_cnt + 1'b1;
                end
                ADDR: begin
                    addr_buff <= {bus_bit, addr_buff[ADDRESS_WIDTH-1:1]};
                    bit_cnt   <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + 1'b1;
                end
                WDATA: begin
                    data_out_parellel <= {bus_bit, data_out_parellel[DATA_WIDTH-1:1]};
                    bit_cnt           <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                end
                WAIT_DV: begin
                    bit_cnt <= '0;
                    if (module_dv) begin
                        tx_shift <= data_in_parellel;
                    end
                end
                TX: begin
                    // The start bit occupies count 0, so shifting begins only
                    // once a data bit has been on the wire.
                    if (bit_cnt != '0) begin
                        tx_shift <= tx_shift >> 1;
                    end
                    bit_cnt <= bit_cnt + 1'b1;
                end
                SKIP: begin
                    if (!skip_data) begin
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt   <= '0;
                            skip_data <= rd_wrt;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt   <= '0;
                            skip_data <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_slave.sv
// tb_serial_bus_slave: directed bench for serial_bus_slave. The master side of
// the bus is a tristate driver with a pull-up, so a released line reads as 1.
module tb_serial_bus_slave;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rd_wrt;
    logic          bus_util;
    logic          module_dv;
    logic          arbiter_cmd_in;
    logic [DW-1:0] data_in_parellel;
    logic          write_en_internal;
    logic [DW-1:0] data_out_parellel;
    logic [AW-1:0] addr_buff;
    logic          busy_out;

    wire           bus;
    logic          tb_oe;
    logic          tb_bit;

    int            checks = 0;
    int            failures = 0;
    logic          watch = 1'b0;
    logic          saw_activity = 1'b0;
    logic [7:0]    exp_byte;

    assign bus = tb_oe ? tb_bit : 1'bz;
    pullup (bus);

    serial_bus_slave #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .SELF_ID       (3'b110)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .rd_wrt            (rd_wrt),
        .bus_util          (bus_util),
        .module_dv         (module_dv),
        .data_bus_serial   (bus),
        .arbiter_cmd_in    (arbiter_cmd_in),
        .data_in_parellel  (data_in_parellel),
        .write_en_internal (write_en_internal),
        .data_out_parellel (data_out_parellel),
        .addr_buff         (addr_buff),
        .busy_out          (busy_out)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Flags any busy/strobe activity while a foreign frame is on the bus.
    always @(negedge clk) begin
        if (watch && (busy_out || write_en_internal)) begin
            saw_activity <= 1'b1;
        end
    end

    // Absolute time limit so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one bit per cycle from a negedge; returns on the negedge after
    // the DUT has sampled the last bit.
    task automatic send_bits(input logic [31:0] value, input int count);
        for (int i = 0; i < count; i++) begin
            tb_oe  = 1'b1;
            tb_bit = value[i];
            @(negedge clk);
        end
    endtask

    task automatic release_bus();
        tb_oe    = 1'b0;
        tb_bit   = 1'b1;
        bus_util = 1'b1;
    endtask

    // Directed sequence.
    initial begin
        rstn             = 1'b1;
        rd_wrt           = 1'b0;
        bus_util         = 1'b1;
        module_dv        = 1'b0;
        arbiter_cmd_in   = 1'b0;
        data_in_parellel = '0;
        tb_oe            = 1'b0;
        tb_bit           = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_busy", busy_out, 0);
        check_output("rst_we", write_en_internal, 0);
        check_output("rst_addr", addr_buff, 0);
        check_output("rst_dout", data_out_parellel, 0);
        check_output("rst_bus_released", bus, 1);
        rstn = 1'b0;
        @(negedge clk);

        $display("[TB] start-like bits while bus_util=1 are ignored");
        bus_util = 1'b1;
        send_bits(32'b1100, 4);
        send_bits(32'h0, 6);
        release_bus();
        check_output("util_high_busy", busy_out, 0);

        $display("[TB] idle line with bus_util=0, then read frame");
        bus_util = 1'b0;
        repeat (4) @(negedge clk);
        check_output("idle_busy", busy_out, 0);
        rd_wrt = 1'b0;
        send_bits(32'h0, 1);
        send_bits(32'b110, 3);
        check_output("rd1_busy_after_id", busy_out, 1);
        bus_util = 1'b1;
        send_bits(32'h0010, AW);
        release_bus();
        check_output("rd1_addr", addr_buff, 32'h0010);
        check_output("rd1_busy_addr", busy_out, 1);
        check_output("rd1_we", write_en_internal, 0);
        repeat (3) @(negedge clk);
        check_output("rd1_no_drive_wait_dv", bus, 1);
        check_output("rd1_busy_wait_dv", busy_out, 1);

        data_in_parellel = 8'd159;
        module_dv        = 1'b1;
        @(negedge clk);
        module_dv        = 1'b0;
        data_in_parellel = 8'h00;
        repeat (2) @(negedge clk);
        check_output("rd1_no_drive_wait_gnt", bus, 1);
        arbiter_cmd_in = 1'b1;
        @(negedge clk);
        arbiter_cmd_in = 1'b0;
        check_output("rd1_tx_start", bus, 0);
        check_output("rd1_busy_tx", busy_out, 1);
        exp_byte = 8'h9F;
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            check_output($sformatf("rd1_tx_bit%0d", i), bus, exp_byte[i]);
        end
        @(negedge clk);
        check_output("rd1_tx_release", bus, 1);
        check_output("rd1_busy_done", busy_out, 0);

        $display("[TB] second read, data ending in 0");
        bus_util = 1'b0;
        rd_wrt   = 1'b0;
        send_bits(32'h0, 1);
        send_bits(32'b110, 3);
        bus_util = 1'b1;
        send_bits(32'h5A5A, AW);
        release_bus();
        check_output("rd2_addr", addr_buff, 32'h5A5A);
        data_in_parellel = 8'h35;
        module_dv        = 1'b1;
        @(negedge clk);
        module_dv      = 1'b0;
        arbiter_cmd_in = 1'b1;
        @(negedge clk);
        arbiter_cmd_in = 1'b0;
        check_output("rd2_tx_start", bus, 0);
        exp_byte = 8'h35;
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            check_output($sformatf("rd2_tx_bit%0d", i), bus, exp_byte[i]);
        end
        @(negedge clk);
        check_output("rd2_tx_release", bus, 1);
        check_output("rd2_busy_done", busy_out, 0);

        $display("[TB] write frame");
        bus_util = 1'b0;
        rd_wrt   = 1'b1;
        send_bits(32'h0, 1);
        send_bits(32'b110, 3);
        check_output("wr_busy_after_id", busy_out, 1);
        bus_util = 1'b1;
        send_bits(32'h0010, AW);
        check_output("wr_we_early", write_en_internal, 0);
        send_bits(32'h9F, DW);
        release_bus();
        check_output("wr_we_pulse", write_en_internal, 1);
        check_output("wr_dout", data_out_parellel, 32'h9F);
        check_output("wr_addr", addr_buff, 32'h0010);
        check_output("wr_busy_strobe", busy_out, 1);
        @(negedge clk);
        check_output("wr_we_one_cycle", write_en_internal, 0);
        check_output("wr_busy_done", busy_out, 0);

        $display("[TB] foreign write frame followed by matching write");
        bus_util = 1'b0;
        rd_wrt   = 1'b1;
        watch    = 1'b1;
        send_bits(32'h0, 1);
        send_bits(32'b101, 3);
        check_output("fr_busy_after_id", busy_out, 0);
        send_bits(32'h0, AW);
        send_bits(32'h0, DW);
        watch = 1'b0;
        check_output("fr_addr_kept", addr_buff, 32'h0010);
        check_output("fr_dout_kept", data_out_parellel, 32'h9F);
        check_output("fr_busy_end", busy_out, 0);
        send_bits(32'h0, 1);
        send_bits(32'b110, 3);
        check_output("wr2_busy_after_id", busy_out, 1);
        send_bits(32'h1234, AW);
        send_bits(32'hC3, DW);
        release_bus();
        check_output("wr2_we_pulse", write_en_internal, 1);
        check_output("wr2_dout", data_out_parellel, 32'hC3);
        check_output("wr2_addr", addr_buff, 32'h1234);
        @(negedge clk);
        check_output("wr2_we_one_cycle", write_en_internal, 0);
        check_output("fr_no_activity", saw_activity, 0);

        $display("[TB] reset in the middle of a read response");
        bus_util = 1'b0;
        rd_wrt   = 1'b0;
        send_bits(32'h0, 1);
        send_bits(32'b110, 3);
        bus_util = 1'b1;
        send_bits(32'h0003, AW);
        release_bus();
        data_in_parellel = 8'hAA;
        module_dv        = 1'b1;
        @(negedge clk);
        module_dv      = 1'b0;
        arbiter_cmd_in = 1'b1;
        @(negedge clk);
        arbiter_cmd_in = 1'b0;
        check_output("rd3_tx_start", bus, 0);
        repeat (3) @(negedge clk);
        check_output("rd3_tx_bit2", bus, 0);
        rstn = 1'b1;
        #1;
        check_output("mid_rst_bus", bus, 1);
        check_output("mid_rst_busy", busy_out, 0);
        check_output("mid_rst_we", write_en_internal, 0);
        check_output("mid_rst_addr", addr_buff, 0);
        check_output("mid_rst_dout", data_out_parellel, 0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_output("post_rst_bus", bus, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
